// File: rtl/bin_to_bcd_8digits_if.sv
// Handshake and result bundle between a requester and the 8-digit binary-to-BCD converter.
// The requester drives enable/start/bin_in; the converter returns status and the display data.
interface bin_to_bcd_8digits_if #(
  parameter int BIN_WIDTH = 27
);
  logic                 enable;
  logic                 start;
  logic [BIN_WIDTH-1:0] bin_in;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [31:0]          bcd_out;
  logic [7:0]           blank_mask;

  modport master (
    output enable, start, bin_in,
    input  busy, done, overflow, bcd_out, blank_mask
  );

  modport slave (
    input  enable, start, bin_in,
    output busy, done, overflow, bcd_out, blank_mask
  );
endinterface

// File: rtl/bin_to_bcd_8digits.sv
// Sequential double-dabble converter: one shift per enabled clock, producing 8 packed BCD digits
// plus a leading-zero blanking mask and a saturation flag for the 7-segment display stage.
module bin_to_bcd_8digits #(
  parameter int BIN_WIDTH = 27
) (
  input  logic                  clock,
  input  logic                  reset_n,
  bin_to_bcd_8digits_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
  localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;
  localparam logic [31:0] SATURATED = 32'h9999_9999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [31:0]          scratch;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_pending;
  logic                 busy_q;
  logic                 done_q;
  logic                 overflow_q;
  logic [31:0]          bcd_q;
  logic [7:0]           blank_q;

  logic [31:0]              adjusted;
  logic [32+BIN_WIDTH-1:0]  shifted;
  logic [31:0]              scratch_next;
  logic [BIN_WIDTH-1:0]     bin_next;
  logic                     in_too_big;

  // Bit i is set while every digit from 7 down to i is zero; digit 0 is never blanked.
  function automatic logic [7:0] leading_zero_mask(input logic [31:0] value);
    logic [7:0] mask;
    logic       all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      all_zero = all_zero && (value[4*i +: 4] == 4'd0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < 8; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted      = {adjusted, bin_sr} << 1;
    scratch_next = shifted[32+BIN_WIDTH-1:BIN_WIDTH];
    bin_next     = shifted[BIN_WIDTH-1:0];
    in_too_big   = {{(32-BIN_WIDTH){1'b0}}, bus.bin_in} > MAX_DISPLAY;
  end

  // Results only update on the completing edge so the display never sees partial digits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bin_sr      <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= 8'hFE;
    end else if (bus.enable) begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bin_sr      <= bus.bin_in;
            scratch     <= '0;
            cnt         <= CNT_LOAD;
            ovf_pending <= in_too_big;
            busy_q      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin_sr  <= bin_next;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_q      <= ovf_pending ? SATURATED : scratch_next;
            blank_q    <= ovf_pending ? 8'h00 : leading_zero_mask(scratch_next);
            overflow_q <= ovf_pending;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.blank_mask = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_8digits.sv
// Scoreboard bench for bin_to_bcd_8digits: directed conversions push hand-computed results,
// and an independent monitor checks each done pulse for value, mask, flag and latency.
module tb_bin_to_bcd_8digits;

  localparam int BIN_WIDTH  = 27;
  localparam int CONV_EDGES = 27;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  mask;
    logic        ovf;
    int          accept_edge;
    int          lat;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  bin_to_bcd_8digits_if #(.BIN_WIDTH(BIN_WIDTH)) bus ();

  bin_to_bcd_8digits #(.BIN_WIDTH(BIN_WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   edge_cnt = 0;
  logic done_prev = 1'b0;

  always @(posedge clock) edge_cnt++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: each rising done is matched against the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 at edge %0d, expected no completion", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output({e.name, "_bcd"}, bus.bcd_out, e.bcd);
        check_output({e.name, "_mask"}, {24'd0, bus.blank_mask}, {24'd0, e.mask});
        check_output({e.name, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
        check_output({e.name, "_latency"}, 32'(edge_cnt - e.accept_edge), 32'(e.lat));
      end
    end
    done_prev = bus.done;
  end

  task automatic push_exp(input logic [31:0] bcd, input logic [7:0] mask, input logic ovf,
                          input int accept_edge, input int lat, input string name);
    exp_t e;
    e.bcd = bcd;
    e.mask = mask;
    e.ovf = ovf;
    e.accept_edge = accept_edge;
    e.lat = lat;
    e.name = name;
    sb.push_back(e);
  endtask

  // One conversion; optionally pokes a stray start or drops enable partway through.
  task automatic apply_stimulus(input logic [BIN_WIDTH-1:0] value, input logic [31:0] exp_bcd,
                                input logic [7:0] exp_mask, input logic exp_ovf, input string name,
                                input int poke_at, input int hold_at, input int hold_len,
                                output int busy_n);
    bit got;
    @(negedge clock);
    bus.bin_in = value;
    bus.start  = 1'b1;
    push_exp(exp_bcd, exp_mask, exp_ovf, edge_cnt + 1, CONV_EDGES + hold_len, name);
    busy_n = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (i == poke_at) begin
        bus.start  = 1'b1;
        bus.bin_in = 1;
      end
      if (i == hold_at) bus.enable = 1'b0;
      if (i == hold_at + hold_len) bus.enable = 1'b1;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got no done within 200 cycles, expected done", name);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_output({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check_output({tag, "_ovf"}, {31'd0, bus.overflow}, 32'd0);
    check_output({tag, "_bcd"}, bus.bcd_out, 32'h0000_0000);
    check_output({tag, "_mask"}, {24'd0, bus.blank_mask}, 32'h0000_00FE);
  endtask

  initial begin
    #100000;
    mismatched++;
    $display("[TB] FAIL watchdog: got simulation still running at 100us, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int busy_n;
    int dones;
    int done_seen;
    int base;

    bus.enable = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    reset_n    = 1'b0;

    #12;
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check_reset_values("idle_after_reset");

    apply_stimulus(27'd12_345_678, 32'h1234_5678, 8'h00, 1'b0, "conv_12345678", -1, -1, 0, busy_n);
    check_output("busy_cycles_12345678", 32'(busy_n), 32'd27);

    apply_stimulus(27'd0, 32'h0000_0000, 8'hFE, 1'b0, "conv_0", -1, -1, 0, busy_n);
    apply_stimulus(27'd99_999_999, 32'h9999_9999, 8'h00, 1'b0, "conv_max", -1, -1, 0, busy_n);
    apply_stimulus(27'd405, 32'h0000_0405, 8'hF8, 1'b0, "conv_405", -1, -1, 0, busy_n);
    apply_stimulus(27'd100_000_000, 32'h9999_9999, 8'h00, 1'b1, "conv_overflow", -1, -1, 0, busy_n);
    apply_stimulus(27'd7, 32'h0000_0007, 8'hFE, 1'b0, "conv_7", -1, -1, 0, busy_n);

    apply_stimulus(27'd42, 32'h0000_0042, 8'hFC, 1'b0, "conv_42_stray_start", 5, -1, 0, busy_n);

    apply_stimulus(27'd31_415_926, 32'h3141_5926, 8'h00, 1'b0, "conv_enable_hold", -1, 10, 10, busy_n);
    check_output("busy_cycles_enable_hold", 32'(busy_n), 32'd37);

    // Held start: three back-to-back conversions, each accepted 28 edges after the previous.
    @(negedge clock);
    bus.bin_in = 27'd9;
    bus.start  = 1'b1;
    base = edge_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      push_exp(32'h0000_0009, 8'hFE, 1'b0, base + 28 * k, CONV_EDGES, $sformatf("held_%0d", k));
    end
    dones = 0;
    for (int i = 0; i < 200 && dones < 3; i++) begin
      @(negedge clock);
      if (bus.done) begin
        dones++;
        if (dones == 3) bus.start = 1'b0;
      end
    end
    check_output("held_start_done_count", 32'(dones), 32'd3);

    // Abort mid-conversion with reset; no result may appear for the aborted request.
    @(negedge clock);
    bus.bin_in = 27'd500;
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clock);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) done_seen++;
    end
    check_output("abort_no_done", 32'(done_seen), 32'd0);

    apply_stimulus(27'd255, 32'h0000_0255, 8'hF8, 1'b0, "conv_255_after_abort", -1, -1, 0, busy_n);

    repeat (5) @(negedge clock);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_8digits.md
Name: bin_to_bcd_8digits

Overview:
- Sequential double-dabble converter: turns an unsigned binary value into 8 packed BCD digits (hex7..hex0 order, digit 7 = MSD).
- Sits directly upstream of the 8-display BCD-to-7-segment decoder; bcd_out nibble i drives display i.
- Start/busy/done handshake; one shift per enabled clock.
- Also produces a leading-zero blanking mask and a saturation/overflow flag for the display stage.

Parameters:
- BIN_WIDTH, 27, width of bin_in; legal range 4..27 (2^27 covers 99,999,999).

Ports:
- clock  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  clock enable; when 0, all state and outputs hold
- start  input  1  conversion request, sampled in IDLE when enable=1
- bin_in  input  BIN_WIDTH  unsigned value, captured on the accepting edge
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse, result valid
- overflow  output  1  captured value exceeded 99,999,999
- bcd_out  output  32  packed BCD result, [31:28]=digit 7 … [3:0]=digit 0
- blank_mask  output  8  bit i=1 means digit i is a leading zero

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE, busy=0, done=0, overflow=0.
  - bcd_out=32'h0000_0000, blank_mask=8'hFE.
  - Internal shift and counter registers cleared.
- States: IDLE, SHIFT. Every transition and register update requires enable=1. With enable=0, everything holds, including a high done.
- IDLE:
  - On an edge with start=1: capture bin_in into the shift register and clear the BCD scratch.
  - Set cnt=BIN_WIDTH and busy=1, and go to SHIFT.
  - Latch ovf_pending = (bin_in > 99_999_999).
  - done is cleared on any enabled edge that does not complete a conversion.
- SHIFT, each enabled edge:
  - For each scratch nibble that is ≥5, add 3 (all nibbles evaluated in parallel, combinationally).
  - Then shift {scratch, binary} left by 1 and decrement cnt.
  - On the edge where cnt goes 1→0:
    - bcd_out ← final scratch; if ovf_pending, bcd_out ← 32'h9999_9999 instead.
    - overflow ← ovf_pending.
    - blank_mask ← computed from the new bcd_out value.
    - done ← 1, busy ← 0, state ← IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E_BIN_WIDTH. That is 27 enabled edges at default; each enable=0 cycle adds one.
- busy is high from E0 through E_BIN_WIDTH.
- bcd_out, overflow and blank_mask hold their last result until the next completion. They do not change during SHIFT.
- start while busy is ignored, with no queuing.
- start on the completing edge is also ignored. start must be re-asserted, or held, in the IDLE cycle that follows.
- start held continuously gives back-to-back conversions: one IDLE cycle between them, coinciding with the done pulse.
- bin_in is don't-care except on the accepting edge.
- blank_mask:
  - Bit i (i=7..1) = 1 iff digits 7..i are all zero.
  - Bit 0 is always 0 (a lone zero is always shown).
  - On overflow, blank_mask = 8'h00.
- Reset asserted mid-conversion aborts immediately to reset values. No done is produced. The next start after release converts normally.
- Scratch nibbles never exceed 9 after a shift, so no internal overflow occurs for legal BIN_WIDTH. Digits above the input range stay 0.

Test Plan:
- Reset check: reset_n=0 → busy=0, done=0, overflow=0, bcd_out=0, blank_mask=8'hFE. Release, idle 5 cycles → no change.
- bin_in=12_345_678, start for 1 cycle, enable=1:
  - bcd_out=32'h1234_5678, blank_mask=8'h00, overflow=0.
  - done pulses exactly 27 edges after acceptance.
  - busy high for exactly 27 cycles.
- Boundary values:
  - bin_in=0 → bcd_out=0, blank_mask=8'hFE.
  - bin_in=99_999_999 → 32'h9999_9999, overflow=0.
  - bin_in=405 → 32'h0000_0405, blank_mask=8'hF8.
- Overflow: bin_in=100_000_000 → bcd_out=32'h9999_9999, overflow=1, blank_mask=8'h00. A following bin_in=7 → 32'h0000_0007, overflow=0, blank_mask=8'hFE.
- Handshake edge cases:
  - Pulse start with bin_in=1 at cycle 5 of a conversion of 42 → ignored; result 32'h0000_0042.
  - Hold start high with bin_in=9 → done every 28 cycles.
- Enable and reset interaction:
  - Drop enable for 10 cycles mid-conversion → done delayed exactly 10 cycles, result unchanged.
  - Assert reset_n=0 mid-conversion → outputs return to reset values, no done pulse; the next conversion of 255 gives 32'h0000_0255.
